// File: rtl/fifo_pkg.sv
// fifo_pkg - shared definitions for the fifo_ctr block.
//   FIFO_DATA_W_DEF / FIFO_ADDR_W_DEF : default word width and pointer width
//   fifo_op_t / OP_*                  : effective operation code {do_rd, do_wr}
//   clog2()                           : ceiling log2 for elaboration-time sizing
package fifo_pkg;

  localparam int FIFO_DATA_W_DEF = 8;
  localparam int FIFO_ADDR_W_DEF = 4;

  typedef logic [1:0] fifo_op_t;

  localparam fifo_op_t OP_NOP  = 2'b00;
  localparam fifo_op_t OP_WR   = 2'b01;
  localparam fifo_op_t OP_RD   = 2'b10;
  localparam fifo_op_t OP_RDWR = 2'b11;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_ctr_if.sv
// fifo_ctr_if - producer/consumer bus of the fifo_ctr block.
//   clr, wr, wr_data, rd      : requests toward the FIFO
//   rd_data                   : show-ahead head word
//   full, empty, almost_full,
//   almost_empty, count       : registered status
//   overflow, underflow       : sticky error flags, only with FIFO_ERR_FLAGS_EN
// Modports: master = user side, slave = FIFO side.
interface fifo_ctr_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W_DEF,
  parameter int ADDR_W = FIFO_ADDR_W_DEF
) ();

  logic              clr;
  logic              wr;
  logic [DATA_W-1:0] wr_data;
  logic              rd;
  logic [DATA_W-1:0] rd_data;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
`ifdef FIFO_ERR_FLAGS_EN
  logic              overflow;
  logic              underflow;

  modport master (
    output clr, wr, wr_data, rd,
    input  rd_data, full, empty, almost_full, almost_empty, count,
    input  overflow, underflow
  );

  modport slave (
    input  clr, wr, wr_data, rd,
    output rd_data, full, empty, almost_full, almost_empty, count,
    output overflow, underflow
  );
`else
  modport master (
    output clr, wr, wr_data, rd,
    input  rd_data, full, empty, almost_full, almost_empty, count
  );

  modport slave (
    input  clr, wr, wr_data, rd,
    output rd_data, full, empty, almost_full, almost_empty, count
  );
`endif

endinterface

// File: rtl/fifo_mem.sv
// fifo_mem - simple dual-port register file backing the FIFO.
//   clk   : write clock
//   we    : write enable, wdata stored at waddr on the rising edge
//   raddr : asynchronous read address, rdata follows it combinationally
// Contents are never reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W_DEF,
  parameter int ADDR_W = FIFO_ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_ctr.sv
// fifo_ctr - synchronous show-ahead FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and a synchronous flush.
//   clk : clock, everything on the rising edge
//   rst : synchronous active-high reset
//   bus : fifo_ctr_if.slave (clr, wr/wr_data, rd/rd_data, status flags, count)
// Optional macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags on bus.
module fifo_ctr
  import fifo_pkg::*;
#(
  parameter int DATA_W    = FIFO_DATA_W_DEF,
  parameter int ADDR_W    = FIFO_ADDR_W_DEF,
  parameter int AF_THRESH = 2**ADDR_W - 2,
  parameter int AE_THRESH = 2
) (
  input logic       clk,
  input logic       rst,
  fifo_ctr_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0]  AE_C    = CNT_W'(AE_THRESH);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  if (AE_THRESH < 0 || AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH) begin : g_bad_thresh
    $error("fifo_ctr: thresholds must satisfy 0 <= AE_THRESH < AF_THRESH <= DEPTH");
  end

  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_next;
  logic [CNT_W-1:0]  cnt_src;
  logic              full_q;
  logic              empty_q;
  logic              af_q;
  logic              ae_q;
  logic              flush;
  logic              do_wr;
  logic              do_rd;
  fifo_op_t          op;
  logic [DATA_W-1:0] rd_data_w;

  assign flush = rst | bus.clr;

  // A write to a full FIFO is legal when the same cycle pops the head.
  assign do_wr = bus.wr & (~full_q | bus.rd);
  assign do_rd = bus.rd & ~empty_q;
  assign op    = {do_rd, do_wr};

  always_comb begin
    count_next = count_q;
    case (op)
      OP_WR:   count_next = count_q + CNT_ONE;
      OP_RD:   count_next = count_q - CNT_ONE;
      OP_NOP,
      OP_RDWR: count_next = count_q;
      default: count_next = count_q;
    endcase
    // Flags after rst/clr are derived from an empty FIFO, so the flush
    // and reset values come out of the same comparators.
    cnt_src = flush ? '0 : count_next;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      count_q <= count_next;
    end
    full_q  <= (cnt_src == DEPTH_C);
    empty_q <= (cnt_src == '0);
    af_q    <= (cnt_src >= AF_C);
    ae_q    <= (cnt_src <= AE_C);
  end

  // The write is blocked during a flush so clr leaves memory untouched.
  fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (do_wr & ~flush),
    .waddr (wr_ptr),
    .wdata (bus.wr_data),
    .raddr (rd_ptr),
    .rdata (rd_data_w)
  );

  assign bus.rd_data      = rd_data_w;
  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q;
  logic udf_q;

  always_ff @(posedge clk) begin
    if (flush) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.wr & full_q & ~bus.rd) ovf_q <= 1'b1;
      if (bus.rd & empty_q)          udf_q <= 1'b1;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;
`endif

endmodule

// File: tb/tb_fifo_ctr.sv
module tb_fifo_ctr;

  localparam int DW = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_ctr_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  fifo_ctr #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .AF_THRESH (6),
    .AE_THRESH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [7:0] wd;
    logic       chk;
    logic [7:0] head;
    int         cnt;
    logic       f;
    logic       e;
    logic       af;
    logic       ae;
  } vec_t;

  vec_t vt[$];
  logic [7:0] q[$];

  function automatic vec_t mk(input logic wr, input logic rd, input logic [7:0] wd,
                              input logic chk, input logic [7:0] head, input int cnt,
                              input logic f, input logic e, input logic af, input logic ae);
    vec_t v;
    v.wr = wr; v.rd = rd; v.wd = wd; v.chk = chk; v.head = head;
    v.cnt = cnt; v.f = f; v.e = e; v.af = af; v.ae = ae;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_st(input string tag, input int cnt, input logic f, input logic e,
                          input logic af, input logic ae);
    check({tag, ".count"},        32'(bus.count),        32'(cnt));
    check({tag, ".full"},         32'(bus.full),         32'(f));
    check({tag, ".empty"},        32'(bus.empty),        32'(e));
    check({tag, ".almost_full"},  32'(bus.almost_full),  32'(af));
    check({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(ae));
  endtask

  // Drive one cycle of requests, then sample #1 after the edge.
  task automatic cyc(input logic c, input logic w, input logic r, input logic [7:0] d);
    bus.clr     = c;
    bus.wr      = w;
    bus.rd      = r;
    bus.wr_data = d;
    @(posedge clk);
    #1;
    bus.clr = 1'b0;
    bus.wr  = 1'b0;
    bus.rd  = 1'b0;
  endtask

  initial begin
    bus.clr     = 1'b0;
    bus.wr      = 1'b0;
    bus.rd      = 1'b0;
    bus.wr_data = '0;

    // Fill: 0x11..0x18, head stays 0x11
    for (int k = 0; k < 8; k++)
      vt.push_back(mk(1, 0, 8'(8'h11 + k), 1, 8'h11, k + 1, k == 7, 0, k >= 5, k <= 1));
    vt.push_back(mk(1, 0, 8'h99, 1, 8'h11, 8, 1, 0, 1, 0));  // dropped write on full
    vt.push_back(mk(1, 1, 8'hAA, 1, 8'h12, 8, 1, 0, 1, 0));  // pop+push on full
    vt.push_back(mk(0, 1, 8'h00, 1, 8'h13, 7, 0, 0, 1, 0));
    vt.push_back(mk(0, 1, 8'h00, 1, 8'h14, 6, 0, 0, 1, 0));
    vt.push_back(mk(0, 1, 8'h00, 1, 8'h15, 5, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 8'h00, 1, 8'h16, 4, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 8'h00, 1, 8'h17, 3, 0, 0, 0, 0));
    vt.push_back(mk(0, 1, 8'h00, 1, 8'h18, 2, 0, 0, 0, 1));
    vt.push_back(mk(0, 1, 8'h00, 1, 8'hAA, 1, 0, 0, 0, 1));
    vt.push_back(mk(0, 1, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1));
    vt.push_back(mk(0, 1, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1));  // read on empty ignored
    vt.push_back(mk(1, 1, 8'h5C, 1, 8'h5C, 1, 0, 0, 0, 1));  // rd+wr on empty
    vt.push_back(mk(0, 1, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1));

    // Reset state
    cyc(0, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
    check_st("reset", 0, 0, 1, 0, 1);
`ifdef FIFO_ERR_FLAGS_EN
    check("reset.overflow",  32'(bus.overflow),  32'd0);
    check("reset.underflow", 32'(bus.underflow), 32'd0);
`endif
    rst = 1'b0;

    // Table-driven sequence
    foreach (vt[i]) begin
      cyc(0, vt[i].wr, vt[i].rd, vt[i].wd);
      check_st($sformatf("vec%0d", i), vt[i].cnt, vt[i].f, vt[i].e, vt[i].af, vt[i].ae);
      if (vt[i].chk)
        check($sformatf("vec%0d.rd_data", i), 32'(bus.rd_data), 32'(vt[i].head));
    end

    // Wrap-around with 3 words resident
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 0, 8'(8'h30 + k));
      q.push_back(8'(8'h30 + k));
    end
    for (int k = 0; k < 20; k++) begin
      check($sformatf("wrap%0d.rd_data", k), 32'(bus.rd_data), 32'(q[0]));
      cyc(0, 1, 1, 8'(8'h33 + k));
      void'(q.pop_front());
      q.push_back(8'(8'h33 + k));
      check($sformatf("wrap%0d.count", k), 32'(bus.count), 32'd3);
    end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("wdrain%0d.rd_data", k), 32'(bus.rd_data), 32'(q[0]));
      cyc(0, 0, 1, 8'h00);
      void'(q.pop_front());
    end
    check_st("wrap_end", 0, 0, 1, 0, 1);

    // clr together with wr at count=5
    for (int k = 0; k < 5; k++) cyc(0, 1, 0, 8'(8'h40 + k));
    check_st("pre_clr", 5, 0, 0, 0, 0);
    cyc(1, 1, 0, 8'hEE);
    check_st("clr", 0, 0, 1, 0, 1);
    cyc(0, 1, 0, 8'h77);
    check_st("post_clr", 1, 0, 0, 0, 1);
    check("post_clr.rd_data", 32'(bus.rd_data), 32'h77);
    cyc(0, 0, 1, 8'h00);

    // rst mid-burst together with wr
    for (int k = 0; k < 5; k++) cyc(0, 1, 0, 8'(8'h50 + k));
    rst = 1'b1;
    cyc(0, 1, 0, 8'h5F);
    rst = 1'b0;
    check_st("rst_mid", 0, 0, 1, 0, 1);
    cyc(0, 1, 0, 8'h78);
    check_st("post_rst", 1, 0, 0, 0, 1);
    check("post_rst.rd_data", 32'(bus.rd_data), 32'h78);
    cyc(0, 0, 1, 8'h00);

`ifdef FIFO_ERR_FLAGS_EN
    check("err.ovf0", 32'(bus.overflow),  32'd0);
    check("err.udf0", 32'(bus.underflow), 32'd0);
    cyc(0, 0, 1, 8'h00);
    check("err.udf_set", 32'(bus.underflow), 32'd1);
    check("err.ovf_quiet", 32'(bus.overflow), 32'd0);
    for (int k = 0; k < 8; k++) cyc(0, 1, 0, 8'(8'h60 + k));
    check("err.udf_sticky", 32'(bus.underflow), 32'd1);
    check_st("err.full", 8, 1, 0, 1, 0);
    cyc(0, 1, 1, 8'h68);
    check("err.ovf_rdwr", 32'(bus.overflow), 32'd0);
    cyc(0, 1, 0, 8'h69);
    check("err.ovf_set", 32'(bus.overflow), 32'd1);
    cyc(1, 0, 0, 8'h00);
    check("err.ovf_clr", 32'(bus.overflow),  32'd0);
    check("err.udf_clr", 32'(bus.underflow), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_ctr.md
Name: fifo_ctr

Overview:
- Parametrised synchronous FIFO, successor to the basic pointer/flag FIFO.
- Adds an occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush, and defined full-while-read / empty-while-write semantics.
- Sits between byte/word producers (UART RX, keyboard, DMA-lite engines) and consumers in the same clock domain.
- Show-ahead read port: the head word is always visible on rd_data.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 4, pointer width; DEPTH = 2**ADDR_W entries, all usable.
- AF_THRESH, 2**ADDR_W-2, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous flush; empties the FIFO without touching the memory contents.
- wr  in  1  write request.
- wr_data  in  DATA_W  write data.
- rd  in  1  read request (pop).
- rd_data  out  DATA_W  head word, combinational from memory at rd_ptr.
- full  out  1  registered; count == DEPTH.
- empty  out  1  registered; count == 0.
- almost_full  out  1  registered; count >= AF_THRESH.
- almost_empty  out  1  registered; count <= AE_THRESH.
- count  out  ADDR_W+1  registered occupancy, 0..DEPTH.

Interface (already decided):
- One clock, clk.
- Reset rst is synchronous and active-high.

Behaviour:
- Reset values (rst high at a clk edge): rd_ptr=0, wr_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0). Memory is not reset.
- Priority: rst > clr > rd/wr. clr has exactly the reset effect on pointers and flags, in one cycle.
- Effective operations:
  - do_wr = wr & (~full | rd).
  - do_rd = rd & ~empty.
- Request cases:
  - Write only: mem[wr_ptr] <= wr_data; wr_ptr+1; count+1.
  - Read only: rd_ptr+1; count-1.
  - Both, non-empty and non-full: both pointers advance; count unchanged.
  - Both when full: read pops the head and the write is accepted into the freed slot; count stays DEPTH, full stays 1.
  - Both when empty: write accepted, read ignored; count becomes 1. The written word is not bypassed to rd_data in the same cycle.
  - Write when full without rd: dropped; no state change.
  - Read when empty: ignored; no state change.
- Pointers are ADDR_W bits and wrap modulo DEPTH naturally.
- Timing:
  - count_next = count + do_wr - do_rd.
  - All flags are computed from count_next and registered, so they are valid the cycle after the causing edge.
  - Write-to-read latency: a word written at edge N is on rd_data after edge N (empty drops at the same edge).
- rd_data is undefined (memory content) while empty=1; consumers must qualify it with ~empty.
- Thresholds are compile-time parameters, with 0 <= AE_THRESH < AF_THRESH <= DEPTH required; an elaboration-time check fails the build otherwise.

Optional Feature:
- Macro FIFO_ERR_FLAGS_EN.
- Defined: two extra outputs, overflow and underflow, each 1 bit, sticky.
  - overflow sets on wr & full & ~rd.
  - underflow sets on rd & empty.
  - Both clear on rst or clr; both read 0 after reset.
- Undefined: the ports do not exist; illegal requests are silently ignored as above.

Decomposition:
- Package fifo_pkg:
  - function clog2.
  - localparam defaults for DATA_W and ADDR_W.
  - enum-style localparams for the op code {NOP, WR, RD, RDWR} derived from {do_rd, do_wr}.
- Sub-module fifo_mem: simple dual-port register file with a 2**ADDR_W x DATA_W array, synchronous write on we, asynchronous read at raddr. fifo_ctr holds pointers, count and flags.

Test Plan (ADDR_W=3, DATA_W=8, AF_THRESH=6, AE_THRESH=2):
- Reset then write 0x11..0x18 on 8 consecutive cycles, with 0x11 written first:
  - count steps 1..8.
  - almost_empty drops after the 3rd write.
  - almost_full rises after the 6th write.
  - full=1 after the 8th write.
  - A 9th write of 0x99 is dropped and count stays 8.
- From full, assert rd & wr (0xAA) together for 1 cycle:
  - rd_data changes from 0x11 to 0x12; count=8, full=1.
  - Draining 8 reads yields 0x12..0x18 then 0xAA, after which empty=1.
- From empty, assert rd & wr (0x5C) together:
  - count=1, empty=0, rd_data=0x5C next cycle.
  - A read the following cycle gives empty=1, count=0.
- Wrap-around: 20 cycles of continuous rd & wr with the FIFO holding 3 words (incrementing data) -> count stays 3, and read data order is strictly incrementing across the pointer wrap.
- clr with count=5 asserted simultaneously with wr -> next cycle count=0, empty=1, almost_empty=1; the write is discarded. rst mid-burst behaves identically.
- FIFO_ERR_FLAGS_EN defined:
  - Read on empty -> underflow=1, and it stays 1 through later valid traffic.
  - Write on full without rd -> overflow=1.
  - clr -> both flags 0.
